// File: rtl/digit_serial_addsub_pkg.sv
// Shared types and constants for the digit-serial add/subtract unit.
package addsub_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digit counter width for n digits (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/digit_serial_addsub_if.sv
// Handshake/operand bus of the digit-serial add/subtract unit.
// DSAS_OVF_EN adds the signed-overflow signal ovf.
interface digit_serial_addsub_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef DSAS_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, op_a, op_b, sub, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
`ifdef DSAS_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, op_a, op_b, sub, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
`ifdef DSAS_OVF_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/digit_serial_addsub_cla4_digit.sv
// One 4-bit carry-lookahead digit; all internal carries in flat lookahead form.
module cla4_digit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       c3,
    output logic       g,
    output logic       p
);
    logic [3:0] gb;
    logic [3:0] pb;
    logic       c1;
    logic       c2;

    assign gb = a & b;
    assign pb = a ^ b;

    assign c1 = gb[0] | (pb[0] & ci);
    assign c2 = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & ci);
    assign c3 = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
              | (pb[2] & pb[1] & pb[0] & ci);

    assign g  = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
              | (pb[3] & pb[2] & pb[1] & gb[0]);
    assign p  = &pb;
    assign co = g | (p & ci);

    assign s  = pb ^ {c3, c2, c1, ci};

endmodule

// File: rtl/digit_serial_addsub.sv
// Multi-cycle add/subtract: one 4-bit lookahead digit per cycle, LSB digit first.
// DSAS_OVF_EN enables the registered signed-overflow output.
module digit_serial_addsub
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    digit_serial_addsub_if.slave bus
);
    localparam int unsigned N     = WIDTH / DIGIT_W;
    localparam int unsigned CNT_W = cnt_w(N);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   res_q;
    logic               c_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;

    logic [DIGIT_W-1:0] sum_d;
    logic               c_d;
    logic               c3_d;
    logic               unused_g;
    logic               unused_p;
    logic               last_digit;

    cla4_digit u_digit (
        .a  (a_q[DIGIT_W-1:0]),
        .b  (b_q[DIGIT_W-1:0]),
        .ci (c_q),
        .s  (sum_d),
        .co (c_d),
        .c3 (c3_d),
        .g  (unused_g),
        .p  (unused_p)
    );

    assign last_digit = (cnt_q == CNT_W'(N - 1));

`ifdef DSAS_OVF_EN
    logic ovf_q;

    // Overflow is the carry into the sign bit disagreeing with the carry out of it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state_q == RUN && last_digit) begin
            ovf_q <= c3_d ^ c_d;
        end else if (state_q == DONE && bus.out_ready) begin
            ovf_q <= 1'b0;
        end
    end

    assign bus.ovf = ovf_q;
`else
    logic unused_c3;
    assign unused_c3 = c3_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            c_q         <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        // Subtraction is A + ~B + 1 through the same adder.
                        a_q        <= bus.op_a;
                        b_q        <= bus.sub ? ~bus.op_b : bus.op_b;
                        c_q        <= bus.sub ? 1'b1 : bus.cin;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    // Operands drain LSB first; result fills from the MSB side.
                    a_q   <= a_q >> DIGIT_W;
                    b_q   <= b_q >> DIGIT_W;
                    res_q <= {sum_d, res_q[WIDTH-1:DIGIT_W]};
                    c_q   <= c_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_digit) begin
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = res_q;
    assign bus.cout      = c_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Directed bench for digit_serial_addsub (WIDTH=16); honours DSAS_OVF_EN.
module tb_digit_serial_addsub;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    digit_serial_addsub_if #(.WIDTH(16)) bus ();

    digit_serial_addsub #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation and wait for out_valid; optionally pulse out_ready mid-RUN.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic ci, input logic poke);
        int waitc;
        int lat;
        waitc = 0;
        while (bus.in_ready !== 1'b1 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.op_a     = a;
        bus.op_b     = b;
        bus.sub      = s;
        bus.cin      = ci;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.op_a     = ~a;
        bus.op_b     = ~b;
        bus.sub      = ~s;
        bus.cin      = ~ci;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            bus.out_ready = (poke && lat == 1);
            @(negedge clk);
            lat++;
        end
        bus.out_ready = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'd4);
    endtask

    task automatic release_result(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_rel_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_rel_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] held_sum;
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.sub       = 1'b0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum",       32'(bus.sum),       32'd0);
        chk("rst_cout",      32'(bus.cout),      32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
`ifdef DSAS_OVF_EN
        chk("rst_ovf",       32'(bus.ovf),       32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Basic add; out_ready pulse during RUN must be ignored.
        run_op("t1", 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1);
        chk("t1_sum",  32'(bus.sum),  32'h5555);
        chk("t1_cout", 32'(bus.cout), 32'd0);
        chk("t1_busy", 32'(bus.busy), 32'd0);
`ifdef DSAS_OVF_EN
        chk("t1_ovf",  32'(bus.ovf),  32'd0);
`endif
        release_result("t1");

        run_op("t2a", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        chk("t2a_sum",  32'(bus.sum),  32'h0000);
        chk("t2a_cout", 32'(bus.cout), 32'd1);
        release_result("t2a");

        run_op("t2b", 16'h000F, 16'h0000, 1'b0, 1'b1, 1'b0);
        chk("t2b_sum",  32'(bus.sum),  32'h0010);
        chk("t2b_cout", 32'(bus.cout), 32'd0);
        release_result("t2b");

        run_op("t3a", 16'h0005, 16'h0007, 1'b1, 1'b0, 1'b0);
        chk("t3a_sum",  32'(bus.sum),  32'hFFFE);
        chk("t3a_cout", 32'(bus.cout), 32'd0);
        release_result("t3a");

        run_op("t3b", 16'h7000, 16'h7000, 1'b1, 1'b1, 1'b0);
        chk("t3b_sum",  32'(bus.sum),  32'h0000);
        chk("t3b_cout", 32'(bus.cout), 32'd1);
        release_result("t3b");

        run_op("t4a", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        chk("t4a_sum",  32'(bus.sum),  32'h8000);
        chk("t4a_cout", 32'(bus.cout), 32'd0);
`ifdef DSAS_OVF_EN
        chk("t4a_ovf",  32'(bus.ovf),  32'd1);
`endif
        release_result("t4a");
`ifdef DSAS_OVF_EN
        chk("t4a_ovf_clr", 32'(bus.ovf), 32'd0);
`endif

        run_op("t4b", 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0);
        chk("t4b_sum",  32'(bus.sum),  32'h7FFF);
        chk("t4b_cout", 32'(bus.cout), 32'd1);
`ifdef DSAS_OVF_EN
        chk("t4b_ovf",  32'(bus.ovf),  32'd1);
`endif
        release_result("t4b");

        // Back-pressure in DONE with stray in_valid pulses.
        run_op("t5", 16'h0101, 16'h0202, 1'b0, 1'b0, 1'b0);
        chk("t5_sum", 32'(bus.sum), 32'h0303);
        held_sum = 16'h0303;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.op_a     = 16'hAAAA;
            bus.op_b     = 16'h1111;
            @(negedge clk);
            chk("t5_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("t5_hold_sum",   32'(bus.sum),       32'(held_sum));
            chk("t5_hold_cout",  32'(bus.cout),      32'd0);
            chk("t5_hold_ready", 32'(bus.in_ready),  32'd0);
        end
        bus.in_valid = 1'b0;
        release_result("t5");
        @(negedge clk);
        chk("t5_idle_busy", 32'(bus.busy), 32'd0);

        // Reset while digit 2 is in flight.
        bus.op_a     = 16'h1111;
        bus.op_b     = 16'h1111;
        bus.sub      = 1'b0;
        bus.cin      = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t6_busy_run", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_busy",  32'(bus.busy),      32'd0);
        chk("t6_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_rst_sum",   32'(bus.sum),       32'd0);
        chk("t6_rst_cout",  32'(bus.cout),      32'd0);
        chk("t6_rst_ready", 32'(bus.in_ready),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_post_ready", 32'(bus.in_ready),  32'd1);
        chk("t6_post_valid", 32'(bus.out_valid), 32'd0);

        run_op("t6b", 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
        chk("t6b_sum",  32'(bus.sum),  32'h0002);
        chk("t6b_cout", 32'(bus.cout), 32'd0);
        release_result("t6b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
